// File: rtl/reg_share_arb_pkg.sv
// Shared types and constants for the register-sharing round-robin arbiter.
// The optional write counter is enabled with the REG_SHARE_ARB_COUNT_EN macro.
package reg_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        HOLD  = 2'b10
    } arb_state_e;

    localparam int WR_COUNT_W = 16;

    // Saturating increment for the committed-write counter.
    function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
        logic [WR_COUNT_W-1:0] r;
        if (v == {WR_COUNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(WR_COUNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit after 'last',
// wrapping modulo N_REQ (non-power-of-2 counts supported).
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             any,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IW-1:0]    pick_idx
);

    int pos_s;

    // Scan from last+1 around the ring and keep the first hit.
    always_comb begin
        any         = 1'b0;
        pick_onehot = '0;
        pick_idx    = '0;
        pos_s       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos_s = (int'(last) + k) % N_REQ;
            if (!any && req[pos_s]) begin
                any                = 1'b1;
                pick_onehot[pos_s] = 1'b1;
                pick_idx           = IW'(pos_s);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that grants one requester at a time, loads its data into
// a shared register and holds the grant; REG_SHARE_ARB_COUNT_EN adds wr_count.
module reg_share_arbiter
    import reg_share_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wr_data,
    output logic [N_REQ-1:0]       gnt,
    output logic                   ack,
    output logic                   busy,
    output logic [WIDTH-1:0]       Q
`ifdef REG_SHARE_ARB_COUNT_EN
    ,
    output logic [WR_COUNT_W-1:0]  wr_count
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    arb_state_e       state_r, state_s;
    logic [N_REQ-1:0] gnt_r, gnt_s;
    logic [IW-1:0]    win_r, win_s;
    logic [IW-1:0]    last_r, last_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic             ack_r, ack_s;
    logic             busy_r, busy_s;

    logic             pick_any_s;
    logic [N_REQ-1:0] pick_onehot_s;
    logic [IW-1:0]    pick_idx_s;

    rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
        .req         (req),
        .last        (last_r),
        .any         (pick_any_s),
        .pick_onehot (pick_onehot_s),
        .pick_idx    (pick_idx_s)
    );

    // Next-state and next-output logic; the pointer advances on both commit and abort.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        win_s   = win_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        q_s     = q_r;
        ack_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    gnt_s   = pick_onehot_s;
                    win_s   = pick_idx_s;
                    state_s = WRITE;
                end else begin
                    gnt_s = '0;
                end
            end
            WRITE: begin
                last_s = win_r;
                if (req[win_r]) begin
                    q_s     = wr_data[int'(win_r)*WIDTH +: WIDTH];
                    ack_s   = 1'b1;
                    cnt_s   = CW'(HOLD_CYCLES - 1);
                    state_s = HOLD;
                end else begin
                    gnt_s   = '0;
                    state_s = IDLE;
                end
            end
            HOLD: begin
                if (cnt_r == '0) begin
                    gnt_s   = '0;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                gnt_s   = '0;
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            win_r   <= '0;
            last_r  <= IW'(N_REQ - 1);
            cnt_r   <= '0;
            q_r     <= '0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            win_r   <= win_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
            q_r     <= q_s;
            ack_r   <= ack_s;
            busy_r  <= busy_s;
        end
    end

    assign gnt  = gnt_r;
    assign ack  = ack_r;
    assign busy = busy_r;
    assign Q    = q_r;

`ifdef REG_SHARE_ARB_COUNT_EN
    logic [WR_COUNT_W-1:0] wr_count_r;

    // Committed-write counter; aborts never raise ack_s so they are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_r <= '0;
        end else if (ack_s) begin
            wr_count_r <= sat_inc(wr_count_r);
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    assign wr_count = wr_count_r;
`endif

endmodule
